rtc_bus_responder: RTL
======================

// Module: rtc_bus_responder
// PURPOSE
//  Synthesizable model of the external RTC chip: the device end of the multiplexed AD/CS/RD/WR/bus
//  interface driven by the RTC port controller. Decodes address/data cycles and keeps BCD
//  time/date and a countdown timer in a register file. Drives active-low IRQ.
//  Used on-board for loopback bring-up and as the bus model in system simulation.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per RTC second (prescaler terminal count, >=2)
//  SYNC_EN   1            1: 2-flop synchronizers on AD/CS/RD/WR; 0: single registered sample
// PORTS
//  clk    in     1  system clock
//  reset  in     1  synchronous, active-low reset
//  AD     in     1  0 = address phase, 1 = data phase
//  CS     in     1  chip select, active-low
//  RD     in     1  read strobe, active-low
//  WR     in     1  write strobe, active-low
//  bus    inout  8  multiplexed address/data; driven only during reads, else 8'hZZ
//  IRQ    out    1  interrupt, active-low
// BEHAVIOUR
//  Reset (reset==0 at clk edge): addr=00, sec/min/hour=00, day=01, month=01, year=00,
//   tsec/tmin/thour=00, CTRL=00, STAT=00, prescaler=0, IRQ=1, bus=Z, strobe history = released.
//  Strobes are sampled through the synchronizer (S = 2 stages, or 1 if SYNC_EN=0). All edges are
//   detected on the sampled versions.
//  Write commit: on the sampled WR rising edge with sampled CS==0.
//   - AD==0: the address register latches bus.
//   - AD==1: the register at addr latches bus.
//   - Commit takes effect S+1 clk edges after the WR pin rises.
//  Read: while sampled CS==0, RD==0, WR==1 and AD==1, bus drives reg[addr].
//   - Drive starts at the 1st edge after the sampled RD falls.
//   - Bus returns to Z at the 1st edge after the sampled RD or CS goes high.
//   - RD and WR both low: no drive, no write.
//  Register map (hex):
//   00 CTRL: bit0 timer enable, bit1 IRQ enable, bit7 clock halt. Other bits read back as written.
//   01 STAT: bit0 timer flag. Writes AND into it, so writing 0 clears the flag.
//   21 sec, 22 min, 23 hour, 24 day, 25 month, 26 year: BCD.
//   41 tsec, 42 tmin, 43 thour: BCD countdown timer.
//   Other addresses: read 00, writes ignored.
//  Tick: prescaler counts 0..TICK_DIV-1. Tick is a 1-cycle pulse at terminal count; the
//   prescaler wraps to 0.
//   - CTRL.7=1: prescaler held at 0 and no ticks are generated.
//  Time increment per tick (BCD):
//   - Each field: if value >= max (binary compare), wrap to min and carry; else +1 BCD.
//   - Bounds: sec/min 00-59, hour 00-23, day 01-dim(month), month 01-12, year 00-99.
//   - dim: 31/30 table; Feb = 29 when year%4==0 (BCD: tens even & ones in {0,4,8}, or tens odd
//     & ones in {2,6}), else 28.
//   - Non-BCD written values are stored as-is. Behaviour on increment follows the rule above.
//  Timer, per tick with CTRL.0=1:
//   - thour:tmin:tsec decrements BCD, borrowing across fields (sec/min 00 -> 59).
//   - At 00:00:00 after a decrement, or if already 00:00:00: STAT.0 <= 1 and CTRL.0 <= 0.
//  IRQ = ~(STAT.0 & CTRL.1), registered, so it is 1 cycle after the flag.
//  Collision: a data write to any of 21-26 or 41-43 in a tick cycle defers the tick by exactly one
//   cycle, and the written value is then incremented. A write to STAT in the same cycle the timer
//   sets the flag leaves the flag set.
//  Reset mid-transfer: bus is Z and the partial cycle is discarded. No write commits on the first
//   sampled WR release after reset.
// TESTING
//  T1 Addr write 21, data write 0x59 (TICK_DIV=10), 10 clks -> read 21=00, 22=01.
//  T2 Set 23:59:59 on 28/02/24, one tick -> 00:00:00, day=29, month=02; repeat with year 23
//     -> day=01, month=03.
//  T3 Set 31/12/99 23:59:59, tick -> all rolled: day 01, month 01, year 00.
//  T4 Timer 00:00:02, CTRL=03 -> IRQ=0 exactly 2 ticks + 1 clk later, CTRL reads 02;
//     write STAT=00 -> IRQ=1 next cycle.
//  T5 Write sec=0x30 in tick cycle -> sec reads 31; reads of addr 7F -> 00; RD&WR low -> bus Z.
//  T6 reset=0 while RD active -> bus Z next edge, all registers at reset values, IRQ=1.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Device end of the multiplexed RTC bus: decodes address/data cycles, keeps BCD time/date and a
// countdown timer, and raises an active-low interrupt when the timer expires.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100_000_000,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AD,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  inout  wire  [7:0] bus,
  output logic       IRQ
);

  localparam int            S        = SYNC_EN ? 2 : 1;
  localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TC       = PW'(TICK_DIV - 1);
  localparam logic [1:0]    SETTLE   = 2'(S + 1);
  localparam logic [11:0]   SYNC_RST = 12'h700;

  logic [11:0] sync_d, sync1_q, samp;
  logic        ad_s, cs_s, rd_s, wr_s;
  logic [7:0]  bus_s;

  logic [7:0] addr_q, addr_d, ctrl_q, ctrl_d, stat_q, stat_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0] day_q, day_d, month_q, month_d, year_q, year_d;
  logic [7:0] tsec_q, tsec_d, tmin_q, tmin_d, thour_q, thour_d;
  logic [PW-1:0] presc_q, presc_d;
  logic       pend_q, pend_d, armed_q, armed_d, wr_prev_q, wr_prev_d;
  logic       drive_q, drive_d, irq_q, irq_d;
  logic [1:0] vcnt_q, vcnt_d;
  logic [7:0] rdata_q, rdata_d;

  logic       settled, wr_rise, wr_fall, commit, addr_wr, data_wr, time_wr;
  logic       tick_raw, tick_due, tick, t_zero, t_done;
  logic [8:0] st_sec, st_min, st_hour, st_day, st_mon, st_year;
  logic [7:0] tdec_s, tdec_m, tdec_h;

  // {carry, next}: wrap to lo with carry at or above hi, otherwise BCD +1
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v >= hi)               return {1'b1, lo};
    else if (v[3:0] >= 4'd9)   return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] days_in(input logic [7:0] mon, input logic [7:0] yr);
    logic leap;
    leap = (!yr[4] && (yr[3:0] == 4'd0 || yr[3:0] == 4'd4 || yr[3:0] == 4'd8)) ||
           ( yr[4] && (yr[3:0] == 4'd2 || yr[3:0] == 4'd6));
    case (mon)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  always_comb sync_d = {AD, CS, RD, WR, bus};

  always_ff @(posedge clk) begin
    if (!reset) sync1_q <= SYNC_RST;
    else        sync1_q <= sync_d;
  end

  generate
    if (SYNC_EN) begin : g_sync2
      logic [11:0] sync2_q;
      always_ff @(posedge clk) begin
        if (!reset) sync2_q <= SYNC_RST;
        else        sync2_q <= sync1_q;
      end
      assign samp = sync2_q;
    end else begin : g_sync1
      assign samp = sync1_q;
    end
  endgenerate

  assign {ad_s, cs_s, rd_s, wr_s, bus_s} = samp;

  always_comb begin
    addr_d  = addr_q;  ctrl_d  = ctrl_q;  stat_d  = stat_q;
    sec_d   = sec_q;   min_d   = min_q;   hour_d  = hour_q;
    day_d   = day_q;   month_d = month_q; year_d  = year_q;
    tsec_d  = tsec_q;  tmin_d  = tmin_q;  thour_d = thour_q;
    t_done  = 1'b0;

    // History is only trusted once the pipeline holds real pin samples, so a
    // write already in progress across reset never gets armed.
    settled   = (vcnt_q == SETTLE);
    vcnt_d    = settled ? vcnt_q : vcnt_q + 2'd1;
    wr_prev_d = wr_s;
    wr_rise   = wr_s & ~wr_prev_q;
    wr_fall   = ~wr_s & wr_prev_q;
    armed_d   = armed_q;
    if (wr_fall && settled) armed_d = 1'b1;
    if (!rd_s && !wr_s)     armed_d = 1'b0;
    if (wr_rise)            armed_d = 1'b0;
    commit  = wr_rise & ~cs_s & armed_q;
    addr_wr = commit & ~ad_s;
    data_wr = commit & ad_s;
    time_wr = data_wr & (addr_q inside {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                        8'h41, 8'h42, 8'h43});

    tick_raw = ~ctrl_q[7] && (presc_q == TC);
    presc_d  = (ctrl_q[7] || tick_raw) ? '0 : presc_q + 1'b1;
    tick_due = tick_raw | pend_q;
    tick     = tick_due & ~time_wr;
    pend_d   = tick_due & time_wr;

    st_sec  = bcd_step(sec_q,   8'h00, 8'h59);
    st_min  = bcd_step(min_q,   8'h00, 8'h59);
    st_hour = bcd_step(hour_q,  8'h00, 8'h23);
    st_day  = bcd_step(day_q,   8'h01, days_in(month_q, year_q));
    st_mon  = bcd_step(month_q, 8'h01, 8'h12);
    st_year = bcd_step(year_q,  8'h00, 8'h99);

    t_zero = ({thour_q, tmin_q, tsec_q} == 24'd0);
    tdec_s = (tsec_q != 8'h00) ? bcd_dec(tsec_q) : 8'h59;
    tdec_m = (tsec_q != 8'h00) ? tmin_q : ((tmin_q != 8'h00) ? bcd_dec(tmin_q) : 8'h59);
    tdec_h = (tsec_q != 8'h00 || tmin_q != 8'h00) ? thour_q : bcd_dec(thour_q);

    if (addr_wr) addr_d = bus_s;
    if (data_wr) begin
      case (addr_q)
        8'h00: ctrl_d  = bus_s;
        8'h01: stat_d  = stat_q & bus_s;
        8'h21: sec_d   = bus_s;
        8'h22: min_d   = bus_s;
        8'h23: hour_d  = bus_s;
        8'h24: day_d   = bus_s;
        8'h25: month_d = bus_s;
        8'h26: year_d  = bus_s;
        8'h41: tsec_d  = bus_s;
        8'h42: tmin_d  = bus_s;
        8'h43: thour_d = bus_s;
        default: ;
      endcase
    end

    if (tick) begin
      sec_d = st_sec[7:0];
      if (st_sec[8]) begin
        min_d = st_min[7:0];
        if (st_min[8]) begin
          hour_d = st_hour[7:0];
          if (st_hour[8]) begin
            day_d = st_day[7:0];
            if (st_day[8]) begin
              month_d = st_mon[7:0];
              if (st_mon[8]) year_d = st_year[7:0];
            end
          end
        end
      end
      if (ctrl_q[0]) begin
        if (t_zero) begin
          t_done = 1'b1;
        end else begin
          tsec_d  = tdec_s;
          tmin_d  = tdec_m;
          thour_d = tdec_h;
          t_done  = ({tdec_h, tdec_m, tdec_s} == 24'd0);
        end
      end
    end

    // Expiry is applied after any bus write so a same-cycle STAT clear cannot lose the flag
    if (t_done) begin
      stat_d[0] = 1'b1;
      ctrl_d[0] = 1'b0;
    end

    drive_d = ~cs_s & ~rd_s & wr_s & ad_s;
    case (addr_q)
      8'h00:   rdata_d = ctrl_q;
      8'h01:   rdata_d = stat_q;
      8'h21:   rdata_d = sec_q;
      8'h22:   rdata_d = min_q;
      8'h23:   rdata_d = hour_q;
      8'h24:   rdata_d = day_q;
      8'h25:   rdata_d = month_q;
      8'h26:   rdata_d = year_q;
      8'h41:   rdata_d = tsec_q;
      8'h42:   rdata_d = tmin_q;
      8'h43:   rdata_d = thour_q;
      default: rdata_d = 8'h00;
    endcase
    irq_d = ~(stat_q[0] & ctrl_q[1]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= 8'h00; ctrl_q  <= 8'h00; stat_q  <= 8'h00;
      sec_q   <= 8'h00; min_q   <= 8'h00; hour_q  <= 8'h00;
      day_q   <= 8'h01; month_q <= 8'h01; year_q  <= 8'h00;
      tsec_q  <= 8'h00; tmin_q  <= 8'h00; thour_q <= 8'h00;
      presc_q <= '0;    pend_q  <= 1'b0;  armed_q <= 1'b0;
      wr_prev_q <= 1'b1; vcnt_q <= 2'd0;
      drive_q <= 1'b0;  rdata_q <= 8'h00; irq_q   <= 1'b1;
    end else begin
      addr_q  <= addr_d;  ctrl_q  <= ctrl_d;  stat_q  <= stat_d;
      sec_q   <= sec_d;   min_q   <= min_d;   hour_q  <= hour_d;
      day_q   <= day_d;   month_q <= month_d; year_q  <= year_d;
      tsec_q  <= tsec_d;  tmin_q  <= tmin_d;  thour_q <= thour_d;
      presc_q <= presc_d; pend_q  <= pend_d;  armed_q <= armed_d;
      wr_prev_q <= wr_prev_d; vcnt_q <= vcnt_d;
      drive_q <= drive_d; rdata_q <= rdata_d; irq_q   <= irq_d;
    end
  end

  assign bus = drive_q ? rdata_q : 8'hzz;
  assign IRQ = irq_q;

endmodule
